pe_mac_collector: RTL and testbench

- Receiving end of the controller's single-PE operand stream.
- Consumes the serial A_PE/W_PE operand pairs under on_PE/rst_PE and accumulates one 3x3 convolution window of 9 products.
- Latches each finished window into one of four result registers, selected by the C11_PE..C22_PE store strobes.
- Exposes the 2x2 output map to the display path, plus per-result valid bits, a completion flag and a sticky protocol-error flag.

---
 rtl/pe_mac_collector.sv | 153 +++++++++++++++
 tb/tb_pe_mac_collector.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_collector.sv
// Receiving end of the single-PE operand stream: accumulates one 3x3 window of
// products and latches finished windows into four result slots under strobes.
module pe_mac_collector #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 9,
  parameter int SKIP   = 1,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              on_PE,
  input  logic              rst_PE,
  input  logic [DATA_W-1:0] A_PE,
  input  logic [DATA_W-1:0] W_PE,
  input  logic              C11_PE,
  input  logic              C12_PE,
  input  logic              C21_PE,
  input  logic              C22_PE,
  output logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  res11,
  output logic [ACC_W-1:0]  res12,
  output logic [ACC_W-1:0]  res21,
  output logic [ACC_W-1:0]  res22,
  output logic [3:0]        res_valid,
  output logic              all_done,
  output logic              err
);

  localparam int TAP_W  = $clog2(TAPS + 1);
  localparam int SKIP_W = (SKIP < 2) ? 1 : $clog2(SKIP);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_ACCUM, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [TAP_W-1:0]    tap_cnt_q, tap_cnt_d;
  logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
  logic [ACC_W-1:0]    res_q [4];
  logic [ACC_W-1:0]    res_d [4];
  logic [3:0]          res_valid_q, res_valid_d;
  logic                all_done_q, all_done_d;
  logic                err_q, err_d;

  logic [3:0]          strobe;
  logic [2*DATA_W-1:0] product;
  logic                multi_strobe;
  logic                last_tap;
  logic                last_skip;

  assign strobe       = {C22_PE, C21_PE, C12_PE, C11_PE};
  assign product      = A_PE * W_PE;
  assign multi_strobe = |(strobe & (strobe - 4'd1));
  assign last_tap     = (tap_cnt_q == TAP_W'(TAPS - 1));
  assign last_skip    = (skip_cnt_q == SKIP_W'(SKIP - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rst_PE) begin
      state_d = S_IDLE;
    end else if (on_PE) begin
      case (state_q)
        S_IDLE:  state_d = (SKIP == 0) ? S_ACCUM : S_SKIP;
        S_SKIP:  if (last_skip) state_d = S_ACCUM;
        S_ACCUM: if (last_tap) state_d = S_HOLD;
        S_HOLD:  state_d = S_HOLD;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Captures read acc_q, so a strobe coinciding with rst_PE sees the pre-clear sum.
  always_comb begin
    acc_d       = acc_q;
    tap_cnt_d   = tap_cnt_q;
    skip_cnt_d  = skip_cnt_q;
    res_valid_d = res_valid_q;
    err_d       = err_q;
    all_done_d  = all_done_q | (&res_valid_q);
    for (int i = 0; i < 4; i++) begin
      res_d[i] = res_q[i];
    end

    if (on_PE) begin
      for (int i = 0; i < 4; i++) begin
        if (strobe[i]) begin
          res_d[i] = acc_q;
        end
      end
      res_valid_d = res_valid_q | strobe;
      if ((|strobe) && ((state_q != S_HOLD) || multi_strobe)) begin
        err_d = 1'b1;
      end
    end

    if (rst_PE) begin
      acc_d      = '0;
      tap_cnt_d  = '0;
      skip_cnt_d = '0;
    end else if (on_PE) begin
      case (state_q)
        S_IDLE: skip_cnt_d = '0;
        S_SKIP: skip_cnt_d = last_skip ? '0 : skip_cnt_q + SKIP_W'(1);
        S_ACCUM: begin
          acc_d     = acc_q + ACC_W'(product);
          tap_cnt_d = tap_cnt_q + TAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      tap_cnt_q   <= '0;
      skip_cnt_q  <= '0;
      res_valid_q <= '0;
      all_done_q  <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      acc_q       <= acc_d;
      tap_cnt_q   <= tap_cnt_d;
      skip_cnt_q  <= skip_cnt_d;
      res_valid_q <= res_valid_d;
      all_done_q  <= all_done_d;
      err_q       <= err_d;
      for (int i = 0; i < 4; i++) begin
        res_q[i] <= res_d[i];
      end
    end
  end

  assign acc       = acc_q;
  assign res11     = res_q[0];
  assign res12     = res_q[1];
  assign res21     = res_q[2];
  assign res22     = res_q[3];
  assign res_valid = res_valid_q;
  assign all_done  = all_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pe_mac_collector.sv
// Self-checking bench for pe_mac_collector: directed windows with literal
// expectations plus randomized traffic compared every cycle to a sample-count model.
module tb_pe_mac_collector;

  localparam int DATA_W = 8;
  localparam int TAPS   = 9;
  localparam int SKIP   = 1;
  localparam int ACC_W  = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic              on_PE, rst_PE;
  logic [DATA_W-1:0] A_PE, W_PE;
  logic [3:0]        strb;
  logic [ACC_W-1:0]  acc, res11, res12, res21, res22;
  logic [3:0]        res_valid;
  logic              all_done, err;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  // Reference model: samples counted since the last clear decide accumulation.
  logic [ACC_W-1:0] mAcc;
  logic [ACC_W-1:0] mRes [4];
  logic [3:0]       mValid;
  bit               mErr, mDone, mDoneNext;
  int               mN, mK;

  pe_mac_collector #(.DATA_W(DATA_W), .TAPS(TAPS), .SKIP(SKIP), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .on_PE(on_PE), .rst_PE(rst_PE),
    .A_PE(A_PE), .W_PE(W_PE),
    .C11_PE(strb[0]), .C12_PE(strb[1]), .C21_PE(strb[2]), .C22_PE(strb[3]),
    .acc(acc), .res11(res11), .res12(res12), .res21(res21), .res22(res22),
    .res_valid(res_valid), .all_done(all_done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mAcc   = '0;
      mValid = '0;
      mErr   = 1'b0;
      mDone  = 1'b0;
      mN     = 0;
      for (int i = 0; i < 4; i++) mRes[i] = '0;
    end else begin
      mDoneNext = mDone || (mValid == 4'hF);
      if (on_PE && strb != 4'd0) begin
        for (int i = 0; i < 4; i++) if (strb[i]) mRes[i] = mAcc;
        mValid = mValid | strb;
        if (mN < SKIP + 1 + TAPS || $countones(strb) > 1) mErr = 1'b1;
      end
      if (rst_PE) begin
        mAcc = '0;
        mN   = 0;
      end else if (on_PE) begin
        mK = mN + 1;
        if (mK >= SKIP + 2 && mK <= SKIP + 1 + TAPS) mAcc = mAcc + A_PE * W_PE;
        if (mN < 1000) mN = mK;
      end
      mDone = mDoneNext;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    cmp("acc", 32'(acc), 32'(mAcc));
    cmp("res11", 32'(res11), 32'(mRes[0]));
    cmp("res12", 32'(res12), 32'(mRes[1]));
    cmp("res21", 32'(res21), 32'(mRes[2]));
    cmp("res22", 32'(res22), 32'(mRes[3]));
    cmp("res_valid", 32'(res_valid), 32'(mValid));
    cmp("all_done", 32'(all_done), 32'(mDone));
    cmp("err", 32'(err), 32'(mErr));
  endtask

  always @(negedge clk) begin
    if (checkEn) checkOutput();
  end

  // Inputs change 1 time unit after the falling edge; returns just after the next one.
  task automatic applyStimulus(input logic on, input logic rp, input logic [7:0] a,
                               input logic [7:0] w, input logic [3:0] s);
    on_PE  = on;
    rst_PE = rp;
    A_PE   = a;
    W_PE   = w;
    strb   = s;
    @(negedge clk);
    #1;
  endtask

  task automatic runCycles(input int n, input logic [7:0] a, input logic [7:0] w);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, a, w, 4'd0);
  endtask

  initial begin
    rst = 1'b1; on_PE = 1'b0; rst_PE = 1'b0; A_PE = '0; W_PE = '0; strb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    cmp("reset_acc", 32'(acc), 32'd0);
    cmp("reset_valid", 32'(res_valid), 32'd0);
    cmp("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    checkEn = 1'b1;

    $display("[TB] window of 1*1, capture into res11");
    applyStimulus(1'b1, 1'b1, 8'd0, 8'd0, 4'd0);
    runCycles(11, 8'd1, 8'd1);
    cmp("t1_acc", 32'(acc), 32'd9);
    applyStimulus(1'b1, 1'b0, 8'd1, 8'd1, 4'b0001);
    cmp("t1_res11", 32'(res11), 32'd9);
    cmp("t1_model_res11", 32'(mRes[0]), 32'd9);
    cmp("t1_valid", 32'(res_valid), 32'b0001);
    cmp("t1_err", 32'(err), 32'd0);

    $display("[TB] max operands, HOLD ignores extra operands");
    applyStimulus(1'b1, 1'b1, 8'd0, 8'd0, 4'd0);
    runCycles(11, 8'd255, 8'd255);
    for (int i = 0; i < 3; i++) runCycles(1, 8'($urandom), 8'($urandom));
    cmp("t2_acc", 32'(acc), 32'd585225);
    cmp("t2_model_acc", 32'(mAcc), 32'd585225);
    applyStimulus(1'b1, 1'b0, 8'd9, 8'd9, 4'b0010);
    cmp("t2_res12", 32'(res12), 32'd585225);

    $display("[TB] stale operand through clear and skip");
    applyStimulus(1'b1, 1'b1, 8'd7, 8'd7, 4'd0);
    runCycles(2, 8'd7, 8'd7);
    runCycles(9, 8'd2, 8'd3);
    cmp("t3_acc", 32'(acc), 32'd54);
    cmp("t3_model_acc", 32'(mAcc), 32'd54);
    applyStimulus(1'b1, 1'b0, 8'd2, 8'd3, 4'b0100);
    cmp("t3_res21", 32'(res21), 32'd54);

    $display("[TB] four controller windows of 2*3");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 8'd2, 8'd3, 4'd0);
      runCycles(11, 8'd2, 8'd3);
      applyStimulus(1'b1, 1'b0, 8'd2, 8'd3, 4'(1 << i));
    end
    cmp("t4_res11", 32'(res11), 32'd54);
    cmp("t4_res12", 32'(res12), 32'd54);
    cmp("t4_res22", 32'(res22), 32'd54);
    cmp("t4_valid", 32'(res_valid), 32'hF);
    cmp("t4_done_early", 32'(all_done), 32'd0);
    runCycles(1, 8'd2, 8'd3);
    cmp("t4_done", 32'(all_done), 32'd1);
    cmp("t4_err", 32'(err), 32'd0);

    $display("[TB] strobe during accumulation, then double strobe");
    applyStimulus(1'b1, 1'b1, 8'd0, 8'd0, 4'd0);
    runCycles(6, 8'd1, 8'd1);
    applyStimulus(1'b1, 1'b0, 8'd1, 8'd1, 4'b0100);
    cmp("t5_res21", 32'(res21), 32'd4);
    cmp("t5_err", 32'(err), 32'd1);
    runCycles(4, 8'd1, 8'd1);
    applyStimulus(1'b1, 1'b0, 8'd1, 8'd1, 4'b0011);
    cmp("t5_res11", 32'(res11), 32'd9);
    cmp("t5_res12", 32'(res12), 32'd9);
    cmp("t5_err_sticky", 32'(err), 32'd1);

    $display("[TB] async reset mid-window, then enable low");
    applyStimulus(1'b1, 1'b1, 8'd0, 8'd0, 4'd0);
    runCycles(7, 8'd1, 8'd1);
    cmp("t6_acc", 32'(acc), 32'd5);
    rst = 1'b1;
    #1;
    cmp("t6_acc_rst", 32'(acc), 32'd0);
    cmp("t6_res11_rst", 32'(res11), 32'd0);
    cmp("t6_valid_rst", 32'(res_valid), 32'd0);
    cmp("t6_done_rst", 32'(all_done), 32'd0);
    cmp("t6_err_rst", 32'(err), 32'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 8'd0, 8'd0, 4'd0);
    runCycles(5, 8'd3, 8'd4);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b0, 8'($urandom), 8'($urandom), 4'($urandom));
    cmp("t6_acc_hold", 32'(acc), 32'd36);
    cmp("t6_valid_hold", 32'(res_valid), 32'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] s;
      for (int b = 0; b < 4; b++) s[b] = ($urandom_range(0, 99) < 4);
      applyStimulus(($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 5),
                    8'($urandom), 8'($urandom), s);
    end

    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
